// File: rtl/rej_pkg.sv
// Shared types and constants for the Kyber uniform rejection sampler.
package rej_pkg;

  localparam int KYBER_Q = 3329;
  localparam int KYBER_N = 256;

  typedef enum logic [1:0] {IDLE, WAIT_BLK, SAMPLE, DONE} rej_state_t;

  typedef logic [11:0] cand_t;

endpackage

// File: rtl/rej_sample_stream_if.sv
// Squeeze-block handshake between the SHAKE128 squeeze port (master) and the sampler (slave).
interface rej_sample_stream_if #(
  parameter int RATE_BYTES = 168
);

  logic                    blk_req;
  logic                    blk_valid;
  logic                    blk_ready;
  logic [RATE_BYTES*8-1:0] blk_data;

  modport master (
    output blk_valid,
    output blk_data,
    input  blk_req,
    input  blk_ready
  );

  modport slave (
    input  blk_valid,
    input  blk_data,
    output blk_req,
    output blk_ready
  );

endinterface

// File: rtl/rej_triple_decode.sv
// Splits one 3-byte group into two 12-bit candidates and decides which of them are kept.
module rej_triple_decode
  import rej_pkg::*;
#(
  parameter int N     = KYBER_N,
  parameter int CTR_W = $clog2(KYBER_N + 1)
) (
  input  logic [7:0]       b0_i,
  input  logic [7:0]       b1_i,
  input  logic [7:0]       b2_i,
  input  logic [CTR_W-1:0] ctr_i,
  input  cand_t            q_i,
  output cand_t            d1_o,
  output cand_t            d2_o,
  output logic             acc1_o,
  output logic             acc2_o,
  output logic [1:0]       n_acc_o
);

  logic [CTR_W:0] slot2;

  assign d1_o   = {b1_i[3:0], b0_i};
  assign d2_o   = {b2_i, b1_i[7:4]};
  assign acc1_o = (d1_o < q_i);

  // d2 only fits if a slot is still free after d1 has been placed
  assign slot2   = {1'b0, ctr_i} + {{CTR_W{1'b0}}, acc1_o};
  assign acc2_o  = (d2_o < q_i) && (slot2 < (CTR_W+1)'(N));
  assign n_acc_o = {1'b0, acc1_o} + {1'b0, acc2_o};

endmodule

// File: rtl/rej_sample_stream.sv
// Streaming rejection sampler: turns XOF squeeze blocks into N coefficients uniform in [0,Q).
// Optional feature: define REJ_SAMPLE_STATS_EN to add rej_cnt/blk_cnt statistics outputs.
module rej_sample_stream
  import rej_pkg::*;
#(
  parameter int N          = KYBER_N,
  parameter int Q          = KYBER_Q,
  parameter int COEFF_W    = 16,
  parameter int RATE_BYTES = 168
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  rej_sample_stream_if.slave     blk,
  output logic                   busy,
  output logic                   done,
  output logic [N*COEFF_W-1:0]   poly_o
`ifdef REJ_SAMPLE_STATS_EN
  ,
  output logic [15:0]            rej_cnt,
  output logic [7:0]             blk_cnt
`endif
);

  localparam int CTR_W = $clog2(N + 1);
  localparam int POS_W = $clog2(RATE_BYTES + 1);
  localparam int BLK_W = RATE_BYTES * 8;

  if (RATE_BYTES % 3 != 0) begin : g_bad_rate
    $error("rej_sample_stream: RATE_BYTES must be a multiple of 3");
  end
  if (COEFF_W < 12) begin : g_bad_coeff_w
    $error("rej_sample_stream: COEFF_W must be at least 12");
  end

  rej_state_t       state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic [BLK_W-1:0] blk_q, blk_d;

  logic [POS_W+2:0] bit_idx;
  logic [7:0]       b0, b1, b2;
  cand_t            d1, d2;
  logic             acc1, acc2;
  logic [1:0]       n_acc;
  logic [CTR_W:0]   slot2;
  logic             sample_en;
  logic             clear_en;
  logic             xfer;

  assign blk.blk_req   = (state_q == WAIT_BLK);
  assign blk.blk_ready = blk.blk_req;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);

  assign xfer      = blk.blk_req && blk.blk_valid;
  assign sample_en = (state_q == SAMPLE);
  assign clear_en  = (state_q == IDLE) && start;

  assign bit_idx = {pos_q, 3'b000};
  assign b0      = blk_q[bit_idx +: 8];
  assign b1      = blk_q[bit_idx + (POS_W+3)'(8) +: 8];
  assign b2      = blk_q[bit_idx + (POS_W+3)'(16) +: 8];

  rej_triple_decode #(
    .N     (N),
    .CTR_W (CTR_W)
  ) u_decode (
    .b0_i    (b0),
    .b1_i    (b1),
    .b2_i    (b2),
    .ctr_i   (ctr_q),
    .q_i     (cand_t'(Q)),
    .d1_o    (d1),
    .d2_o    (d2),
    .acc1_o  (acc1),
    .acc2_o  (acc2),
    .n_acc_o (n_acc)
  );

  assign slot2 = {1'b0, ctr_q} + {{CTR_W{1'b0}}, acc1};

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    ctr_d   = ctr_q;
    blk_d   = blk_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ctr_d   = '0;
          state_d = WAIT_BLK;
        end
      end
      WAIT_BLK: begin
        if (blk.blk_valid) begin
          blk_d   = blk.blk_data;
          pos_d   = '0;
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        ctr_d = ctr_q + CTR_W'(n_acc);
        pos_d = pos_q + POS_W'(3);
        // a block whose tail cannot hold another full triple is exhausted
        if (ctr_d == CTR_W'(N))                    state_d = DONE;
        else if ((int'(pos_d) + 3) > RATE_BYTES)   state_d = WAIT_BLK;
        else                                       state_d = SAMPLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pos_q   <= '0;
      ctr_q   <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      ctr_q   <= ctr_d;
      blk_q   <= blk_d;
    end
  end

  // One register per slot; d1 targets slot ctr, d2 targets slot ctr+acc1, never the same slot
  for (genvar i = 0; i < N; i++) begin : g_slot
    logic             we1, we2;
    logic [COEFF_W-1:0] coef_q;

    assign we1 = sample_en && acc1 && (ctr_q == CTR_W'(i));
    assign we2 = sample_en && acc2 && (slot2 == (CTR_W+1)'(i));

    always_ff @(posedge clk or posedge rst) begin
      if (rst)           coef_q <= '0;
      else if (clear_en) coef_q <= '0;
      else if (we1)      coef_q <= COEFF_W'(d1);
      else if (we2)      coef_q <= COEFF_W'(d2);
    end

    assign poly_o[i*COEFF_W +: COEFF_W] = coef_q;
  end

`ifdef REJ_SAMPLE_STATS_EN
  logic [15:0] rej_cnt_q;
  logic [7:0]  blk_cnt_q;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] a);
    return (a == 8'hFF) ? 8'hFF : a + 8'd1;
  endfunction

  // a d2 dropped by the N limit counts as rejected, hence 2 - n_acc
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rej_cnt_q <= '0;
      blk_cnt_q <= '0;
    end else if (clear_en) begin
      rej_cnt_q <= '0;
      blk_cnt_q <= '0;
    end else begin
      if (sample_en) rej_cnt_q <= sat_add16(rej_cnt_q, 2'd2 - n_acc);
      if (xfer)      blk_cnt_q <= sat_inc8(blk_cnt_q);
    end
  end

  assign rej_cnt = rej_cnt_q;
  assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_rej_sample_stream.sv
// Self-checking bench for rej_sample_stream: constant vectors, corner sequences, random blocks vs a stream model.
module tb_rej_sample_stream;
  import rej_pkg::*;

  localparam int N   = KYBER_N;
  localparam int Q   = KYBER_Q;
  localparam int CW  = 16;
  localparam int RB  = 168;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic [N*CW-1:0]   poly_o;
`ifdef REJ_SAMPLE_STATS_EN
  logic [15:0]       rej_cnt;
  logic [7:0]        blk_cnt;
`endif

  rej_sample_stream_if #(.RATE_BYTES(RB)) bus();

  rej_sample_stream #(
    .N          (N),
    .Q          (Q),
    .COEFF_W    (CW),
    .RATE_BYTES (RB)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .blk    (bus),
    .busy   (busy),
    .done   (done),
    .poly_o (poly_o)
`ifdef REJ_SAMPLE_STATS_EN
    ,
    .rej_cnt(rej_cnt),
    .blk_cnt(blk_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  logic [RB*8-1:0] blkq[$];
  logic [7:0]      strm[$];

  int exp_coef[N];
  int exp_nblk, exp_ntrip, exp_nrej;
  int got_nblk, got_ntrip;

  function automatic int coef(input int i);
    return int'(poly_o[i*CW +: CW]);
  endfunction

  // Reference: walk the byte stream triple by triple, appending accepted values until N are held
  task automatic model();
    int cnt;
    int d1, d2;
    logic [RB*8-1:0] b;
    logic [7:0] x0, x1, x2;
    cnt = 0; exp_nblk = 0; exp_ntrip = 0; exp_nrej = 0;
    for (int i = 0; i < N; i++) exp_coef[i] = 0;
    while (cnt < N && exp_nblk < blkq.size()) begin
      b = blkq[exp_nblk];
      exp_nblk++;
      for (int t = 0; t < RB / 3 && cnt < N; t++) begin
        x0 = b[(3*t)*8 +: 8];
        x1 = b[(3*t+1)*8 +: 8];
        x2 = b[(3*t+2)*8 +: 8];
        d1 = int'(x0) + 256 * (int'(x1) % 16);
        d2 = int'(x1) / 16 + 16 * int'(x2);
        exp_ntrip++;
        if (d1 < Q) begin exp_coef[cnt] = d1; cnt++; end
        else exp_nrej++;
        if (d2 < Q && cnt < N) begin exp_coef[cnt] = d2; cnt++; end
        else exp_nrej++;
      end
    end
    if (cnt < N) $display("note: model ran out of blocks");
  endtask

  task automatic pack_stream();
    int nb;
    logic [RB*8-1:0] b;
    blkq.delete();
    nb = (strm.size() + RB - 1) / RB + 4;
    for (int k = 0; k < nb; k++) begin
      b = '0;
      for (int j = 0; j < RB; j++)
        if (k * RB + j < strm.size()) b[j*8 +: 8] = strm[k*RB + j];
      blkq.push_back(b);
    end
  endtask

  task automatic gen_random(input int mode);
    logic [RB*8-1:0] b;
    logic [7:0] x;
    blkq.delete();
    for (int k = 0; k < 40; k++) begin
      for (int j = 0; j < RB; j++) begin
        x = 8'($urandom_range(0, 255));
        if (mode == 1 && $urandom_range(0, 1) == 1) x = x | 8'hC0;
        b[j*8 +: 8] = x;
      end
      blkq.push_back(b);
    end
  endtask

  task automatic run_poly(input string name, input int stall_pct, input bit noise);
    bit got;
    int bad;
    model();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    got_nblk = 0; got_ntrip = 0; got = 1'b0;
    for (int cyc = 0; cyc < 8000 && !got; cyc++) begin
      if (done) got = 1'b1;
      else begin
        if (busy && !bus.blk_req) got_ntrip++;
        if (bus.blk_req) begin
          bus.blk_valid = ($urandom_range(0, 99) >= stall_pct);
          bus.blk_data  = (got_nblk < blkq.size()) ? blkq[got_nblk] : '0;
          if (bus.blk_valid) got_nblk++;
        end else begin
          bus.blk_valid = noise && ($urandom_range(0, 1) == 1);
          bus.blk_data  = {(RB/4){$urandom()}};
        end
        start = noise && ($urandom_range(0, 3) == 0);
        @(negedge clk);
      end
    end
    start = 1'b0;
    bus.blk_valid = 1'b0;
    check({name, "_done_seen"}, 64'(got), 64'd1);
    bad = N;
    for (int i = 0; i < N; i++)
      if (bad == N && coef(i) != exp_coef[i]) bad = i;
    if (bad != N) $display("  %s slot %0d: dut %0d model %0d", name, bad, coef(bad), exp_coef[bad]);
    check({name, "_first_bad_slot"}, 64'(bad), 64'(N));
    check({name, "_blocks"}, 64'(got_nblk), 64'(exp_nblk));
    check({name, "_sample_cycles"}, 64'(got_ntrip), 64'(exp_ntrip));
`ifdef REJ_SAMPLE_STATS_EN
    check({name, "_rej_cnt"}, 64'(rej_cnt), 64'(exp_nrej));
    check({name, "_blk_cnt"}, 64'(blk_cnt), 64'(exp_nblk));
`endif
    @(negedge clk);
    check({name, "_done_one_cycle"}, {62'd0, done, busy}, 64'd0);
  endtask

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         c0, c1;
  } vec_t;

  vec_t tbl[7];
  bit   ok;

  initial begin
    tbl[0] = '{8'h00, 8'h0D, 8'hFF, 3328, 0};
    tbl[1] = '{8'h01, 8'h0D, 8'hD0, 3328, 0};
    tbl[2] = '{8'h23, 8'h41, 8'h05, 291, 84};
    tbl[3] = '{8'hFF, 8'hFF, 8'hFF, 0, 0};
    tbl[4] = '{8'h00, 8'h10, 8'h00, 0, 1};
    tbl[5] = '{8'h00, 8'hC0, 8'hCF, 0, 3324};
    tbl[6] = '{8'hFF, 8'h0C, 8'h0D, 3327, 208};

    rst = 1'b1; start = 1'b0; bus.blk_valid = 1'b0; bus.blk_data = '0;
    #1;
    check("reset_busy_done", {62'd0, busy, done}, 64'd0);
    check("reset_req_ready", {62'd0, bus.blk_req, bus.blk_ready}, 64'd0);
    check("reset_poly_zero", 64'(poly_o == '0), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {62'd0, busy, bus.blk_req}, 64'd0);

    // All-zero blocks: 3 handshakes, 128 sample cycles
    strm.delete();
    pack_stream();
    run_poly("zeros", 0, 1'b0);
    check("zeros_blocks_const", 64'(got_nblk), 64'd3);
    check("zeros_cycles_const", 64'(got_ntrip), 64'd128);
    check("zeros_slot255", 64'(coef(255)), 64'd0);

    for (int v = 0; v < 7; v++) begin
      strm.delete();
      strm.push_back(tbl[v].b0); strm.push_back(tbl[v].b1); strm.push_back(tbl[v].b2);
      pack_stream();
      run_poly($sformatf("vec%0d", v), 20, 1'b0);
      check($sformatf("vec%0d_slot0", v), 64'(coef(0)), 64'(tbl[v].c0));
      check($sformatf("vec%0d_slot1", v), 64'(coef(1)), 64'(tbl[v].c1));
    end

    // First block all 0xFF yields nothing, then zeros finish the polynomial
    strm.delete();
    for (int j = 0; j < RB; j++) strm.push_back(8'hFF);
    pack_stream();
    run_poly("ff_then_zero", 0, 1'b0);
    check("ff_blocks_const", 64'(got_nblk), 64'd4);
`ifdef REJ_SAMPLE_STATS_EN
    check("ff_rej_const", 64'(rej_cnt), 64'd112);
    check("ff_blk_const", 64'(blk_cnt), 64'd4);
`endif

    // 255 accepts, then a triple with both valid: only d1 fits
    strm.delete();
    for (int j = 0; j < 381; j++) strm.push_back(8'h00);
    strm.push_back(8'h00); strm.push_back(8'h0D); strm.push_back(8'hFF);
    strm.push_back(8'h23); strm.push_back(8'h41); strm.push_back(8'h05);
    for (int j = 0; j < 60; j++) strm.push_back(8'h11);
    pack_stream();
    run_poly("last_slot", 0, 1'b0);
    check("last_slot254", 64'(coef(254)), 64'd3328);
    check("last_slot255", 64'(coef(255)), 64'd291);
    check("last_cycles_const", 64'(got_ntrip), 64'd129);
    check("last_blocks_const", 64'(got_nblk), 64'd3);
`ifdef REJ_SAMPLE_STATS_EN
    check("last_rej_const", 64'(rej_cnt), 64'd2);
`endif

    // Stall in WAIT_BLK, start while busy, then asynchronous reset mid-sample
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (!(bus.blk_req && bus.blk_ready && busy)) ok = 1'b0;
      @(negedge clk);
    end
    check("stall_holds_wait", 64'(ok), 64'd1);
    bus.blk_valid = 1'b1;
    for (int j = 0; j < RB / 3; j++) bus.blk_data[j*24 +: 24] = 24'h054123;
    @(negedge clk); bus.blk_valid = 1'b0;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    check("start_busy_ignored", {62'd0, busy, bus.blk_req}, 64'd2);
    check("sampling_slot0", 64'(coef(0)), 64'd291);
    check("sampling_slot1", 64'(coef(1)), 64'd84);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy_done", {62'd0, busy, done}, 64'd0);
    check("midrst_req_ready", {62'd0, bus.blk_req, bus.blk_ready}, 64'd0);
    check("midrst_poly_zero", 64'(poly_o == '0), 64'd1);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 6; r++) begin
      gen_random(r % 2);
      run_poly($sformatf("rand%0d", r), r * 12, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
